c1908_bist_ctrl: RTL and testbench
==================================

Name: c1908_bist_ctrl

Overview:
Built-in self-test controller for the c1908 combinational netlist, the circuit under test (CUT) built from the gate cells.
- Generates pseudo-random input vectors with an LFSR and drives them onto the CUT inputs.
- Waits a programmable settle time, then compacts each CUT response into a MISR signature.
- After N patterns, compares the signature with a golden value, so a signature mismatch flags a Trojan or fault.

Parameters:
IN_W, 33, CUT input width; also the LFSR width.
OUT_W, 25, CUT output width; also the MISR width.
N_PATTERNS, 1024, number of vectors per run; must be 1 to 65535.
SETTLE, 2, number of cycles each vector is held before capture; must be at least 1.
LFSR_SEED, 33'h1, LFSR value at run start; must be nonzero.
LFSR_TAPS, bits 32 and 19 set, feedback mask for the LFSR (x^33+x^20+1).
MISR_TAPS, bits 24 and 21 set, feedback mask for the MISR (x^25+x^22+1).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  begin a run; sampled in IDLE or DONE only.
abort  in  1  cancel the run and return to IDLE.
golden  in  OUT_W  expected final signature.
cut_out  in  OUT_W  CUT response.
cut_in  out  IN_W  vector driven to the CUT; this is the LFSR register output.
busy  out  1  high in APPLY and CAPTURE.
done  out  1  high in DONE.
pass  out  1  registered compare result; valid while done is high.
signature  out  OUT_W  current MISR value.
pattern_cnt  out  16  number of vectors captured so far.

Behaviour:
- Reset: applies immediately whenever rst is high, including mid-run.
  - State goes to IDLE.
  - cut_in=LFSR_SEED; signature=0; pattern_cnt=0.
  - busy=0, done=0, pass=0; settle counter=0.
- States: IDLE, APPLY, CAPTURE, DONE. All outputs are registered.
- IDLE or DONE with start=1 at a clock edge:
  - Load lfsr=LFSR_SEED, sig=0, cnt=0, settle=0, pass=0.
  - Move to APPLY.
- APPLY: cut_in holds steady.
  - settle increments each cycle.
  - When settle==SETTLE-1, clear settle and move to CAPTURE, so APPLY lasts exactly SETTLE cycles.
- CAPTURE (one cycle):
  - sig <= {sig[OUT_W-2:0], ^(sig & MISR_TAPS)} ^ cut_out.
  - lfsr <= {lfsr[IN_W-2:0], ^(lfsr & LFSR_TAPS)}.
  - cnt <= cnt+1.
  - If cnt==N_PATTERNS-1, move to DONE and set pass <= (next sig == golden). Otherwise move to APPLY.
- DONE: holds sig, cnt and pass until the next start. done stays high as a level, not a pulse.
- Timing: each vector takes SETTLE+1 cycles. done rises N_PATTERNS*(SETTLE+1) cycles after the start edge.
- Ignored inputs: start is ignored in APPLY and CAPTURE. abort is ignored in IDLE.
- abort in APPLY, CAPTURE or DONE: go to IDLE and restore all reset values.
- abort and start high together: abort wins.
- golden is sampled only on the final CAPTURE edge. It may change freely at any other time.
- LFSR wrap: at full period, the sequence repeats without any special handling.
- pattern_cnt never wraps, because N_PATTERNS is at most 65535.

Test Plan:
- LFSR sequence: N=25, SETTLE=1, seed=1. cut_in must equal 1<<k for k=0..19 in successive APPLY windows. Pattern 20 must be 0x100001.
- Zero response: cut_out tied to 0, golden=0, N=4, SETTLE=2. done must rise exactly 12 cycles after the start edge, with signature=0, pass=1, pattern_cnt=4.
- Mismatch: same setup as zero response but golden=1. Result must be done=1, pass=0, signature=0.
- Response compaction: cut_out=cut_in[24:0], N=3, seed=1, SETTLE=1.
  - Signature sequence must be 0x1, then 0x0, then 0x4.
  - Derivation: capture 1 gives 0^1=0x1. Capture 2 gives shift 0x2 ^ 0x2 = 0x0. Capture 3 gives 0x0 ^ 0x4 = 0x4.
  - With golden=0x4, pass must be 1.
- Abort and reset: abort at cycle 5 of the run must return to IDLE with busy=0 and cnt=0. Asserting rst mid-APPLY must clear all outputs asynchronously, before the next clock edge. A following start must give an identical run.
- Ignored and restart start: start pulsed during APPLY must have no effect and no restart. start pulsed in DONE must restart, clearing pass and signature on the same edge.

Source files
------------

// File: rtl/c1908_bist_ctrl.sv
// BIST controller for the c1908 CUT. An LFSR drives the CUT inputs, and each response is
// compacted into a MISR after a settle time. After N patterns the signature is checked against golden.
module c1908_bist_ctrl #(
    parameter int unsigned      IN_W       = 33,
    parameter int unsigned      OUT_W      = 25,
    parameter int unsigned      N_PATTERNS = 1024,
    parameter int unsigned      SETTLE     = 2,
    parameter logic [IN_W-1:0]  LFSR_SEED  = IN_W'(1),
    parameter logic [IN_W-1:0]  LFSR_TAPS  = IN_W'(33'h1_0008_0000),
    parameter logic [OUT_W-1:0] MISR_TAPS  = OUT_W'(25'h120_0000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [OUT_W-1:0] golden,
    input  logic [OUT_W-1:0] cut_out,
    output logic [IN_W-1:0]  cut_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature,
    output logic [15:0]      pattern_cnt
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(N_PATTERNS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_APPLY,
        S_CAPTURE,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [IN_W-1:0]    lfsr_q, lfsr_d;
    logic [OUT_W-1:0]   sig_q, sig_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic               pass_q, pass_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [OUT_W-1:0]   sig_next_c;
    logic [IN_W-1:0]    lfsr_next_c;
    logic               clear_c;
    logic               load_c;

    // Fibonacci-style shift with XOR feedback; MISR folds in the CUT response
    assign sig_next_c  = {sig_q[OUT_W-2:0], ^(sig_q & MISR_TAPS)} ^ cut_out;
    assign lfsr_next_c = {lfsr_q[IN_W-2:0], ^(lfsr_q & LFSR_TAPS)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lfsr_q   <= LFSR_SEED;
            sig_q    <= '0;
            cnt_q    <= '0;
            settle_q <= '0;
            pass_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            sig_q    <= sig_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            pass_q   <= pass_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        sig_d    = sig_q;
        cnt_d    = cnt_q;
        settle_d = settle_q;
        pass_d   = pass_q;
        clear_c  = 1'b0;
        load_c   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                load_c = start && !abort;
            end
            S_APPLY: begin
                if (abort) begin
                    clear_c = 1'b1;
                end else if (settle_q == SETTLE_LAST) begin
                    settle_d = '0;
                    state_d  = S_CAPTURE;
                end else begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            S_CAPTURE: begin
                if (abort) begin
                    clear_c = 1'b1;
                end else begin
                    sig_d  = sig_next_c;
                    lfsr_d = lfsr_next_c;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        pass_d  = (sig_next_c == golden);
                        state_d = S_DONE;
                    end else begin
                        state_d = S_APPLY;
                    end
                end
            end
            S_DONE: begin
                clear_c = abort;
                load_c  = start && !abort;
            end
            default: begin
                clear_c = 1'b1;
            end
        endcase

        // Abort restores reset values; a start reloads the run from the seed
        if (clear_c || load_c) begin
            state_d  = load_c ? S_APPLY : S_IDLE;
            lfsr_d   = LFSR_SEED;
            sig_d    = '0;
            cnt_d    = '0;
            settle_d = '0;
            pass_d   = 1'b0;
        end

        busy_d = (state_d == S_APPLY) || (state_d == S_CAPTURE);
        done_d = (state_d == S_DONE);
    end

    assign cut_in      = lfsr_q;
    assign signature   = sig_q;
    assign pattern_cnt = cnt_q;
    assign pass        = pass_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_c1908_bist_ctrl.sv
// Self-checking bench for c1908_bist_ctrl: a run-time-based reference model checked every cycle,
// plus directed literal checks and a randomized start/abort/reset phase.
module tb_c1908_bist_ctrl;

    localparam int unsigned N   = 25;
    localparam int unsigned S   = 2;
    localparam int unsigned RUN = N * (S + 1);
    localparam logic [32:0] SEED = 33'h1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [24:0] golden = '0;
    logic [24:0] cut_out_r = '0;
    logic [24:0] cut_out;
    logic [32:0] cut_in;
    logic        busy, done, pass;
    logic [24:0] signature;
    logic [15:0] pattern_cnt;
    int          mode = 0;
    bit          chk_en = 1'b0;
    int          n_cmp = 0;
    int          n_err = 0;

    // mode 0: random response, 1: tied low, 2: echo of the low CUT input bits
    assign cut_out = (mode == 1) ? 25'h0 : (mode == 2) ? cut_in[24:0] : cut_out_r;

    c1908_bist_ctrl #(
        .N_PATTERNS(N),
        .SETTLE    (S)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .golden     (golden),
        .cut_out    (cut_out),
        .cut_in     (cut_in),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .signature  (signature),
        .pattern_cnt(pattern_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] lfsr_next(input logic [32:0] x);
        return {x[31:0], x[32] ^ x[19]};
    endfunction

    function automatic logic [24:0] misr_next(input logic [24:0] s);
        return {s[23:0], s[24] ^ s[21]};
    endfunction

    // Final signature for a run whose response echoes cut_in[24:0]
    function automatic logic [24:0] gold_sig(input int n);
        logic [32:0] l;
        logic [24:0] s;
        l = SEED;
        s = '0;
        for (int i = 0; i < n; i++) begin
            s = misr_next(s) ^ l[24:0];
            l = lfsr_next(l);
        end
        return s;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a run is described by edges elapsed since its start edge
    bit              m_act  = 1'b0;
    int unsigned     m_t    = 0;
    logic [32:0]     m_lfsr = SEED;
    logic [24:0]     m_sig  = '0;
    int              m_cnt  = 0;
    bit              m_pass = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst || (abort && m_act) || (start && !abort && (!m_act || m_t == RUN))) begin
            m_act  = !rst && !abort;
            m_t    = 0;
            m_lfsr = SEED;
            m_sig  = '0;
            m_cnt  = 0;
            m_pass = 1'b0;
        end else if (m_act && m_t < RUN) begin
            m_t++;
            if (m_t % (S + 1) == 0) begin
                m_sig  = misr_next(m_sig) ^ cut_out;
                m_lfsr = lfsr_next(m_lfsr);
                m_cnt++;
                if (m_cnt == N) m_pass = (m_sig == golden);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cut_in",      64'(cut_in),      64'(m_lfsr));
            chk("signature",   64'(signature),   64'(m_sig));
            chk("pattern_cnt", 64'(pattern_cnt), 64'(m_cnt));
            chk("busy",        64'(busy),        64'(m_act && m_t < RUN));
            chk("done",        64'(done),        64'(m_act && m_t == RUN));
            chk("pass",        64'(pass),        64'(m_pass));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            cut_out_r = 25'($urandom);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    logic [32:0] exp_in;
    logic [24:0] gold_n;

    initial begin
        gold_n = gold_sig(int'(N));
        cyc(2);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_cut_in", 64'(cut_in), 64'h1);
        chk("rst_sig",    64'(signature), 64'h0);
        chk("rst_cnt",    64'(pattern_cnt), 64'h0);
        chk("rst_flags",  64'({busy, done, pass}), 64'h0);

        // LFSR walks a single one up to bit 19, then the tap at 19 feeds bit 0
        cyc(2);
        pulse_start();
        for (int k = 0; k <= 20; k++) begin
            exp_in = (k < 20) ? (SEED << k) : 33'h10_0001;
            chk("lfsr_pattern", 64'(cut_in), 64'(exp_in));
            cyc(int'(S + 1));
        end
        cyc(int'(RUN - 63));
        chk("lfsr_run_done", 64'({done, pattern_cnt}), 64'({1'b1, 16'd25}));

        // Zero response; restart from DONE clears pass and signature
        mode = 1;
        golden = '0;
        pulse_start();
        chk("restart_clear", 64'({pass, signature, busy}), 64'({1'b0, 25'h0, 1'b1}));
        cyc(int'(RUN - 1));
        chk("zero_done_early", 64'(done), 64'h0);
        cyc(1);
        chk("zero_done",  64'({done, pass}), 64'h3);
        chk("zero_sig",   64'(signature), 64'h0);
        chk("zero_cnt",   64'(pattern_cnt), 64'(N));

        golden = 25'h1;
        pulse_start();
        cyc(int'(RUN));
        chk("mismatch", 64'({done, pass, signature}), 64'({1'b1, 1'b0, 25'h0}));

        // Response compaction: echoed inputs give signatures 1, 0, 4
        mode = 2;
        golden = gold_n;
        pulse_start();
        cyc(int'(S + 1));
        chk("misr_cap1", 64'(signature), 64'h1);
        cyc(int'(S + 1));
        chk("misr_cap2", 64'(signature), 64'h0);
        cyc(int'(S + 1));
        chk("misr_cap3", 64'(signature), 64'h4);
        cyc(int'(RUN - 9));
        chk("compact_pass", 64'({done, pass}), 64'h3);
        chk("compact_sig",  64'(signature), 64'(gold_n));

        // Start during the run is ignored; done timing stays anchored to the first start
        pulse_start();
        cyc(4);
        pulse_start();
        cyc(int'(RUN - 6));
        chk("ign_start_early", 64'(done), 64'h0);
        cyc(1);
        chk("ign_start_done", 64'({done, pass}), 64'h3);

        pulse_start();
        cyc(4);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        chk("abort_idle", 64'({busy, done, pattern_cnt}), 64'h0);
        chk("abort_regs", 64'({cut_in, signature}), 64'({33'h1, 25'h0}));

        abort = 1'b1;
        start = 1'b1;
        cyc(1);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_wins_idle", 64'({busy, done}), 64'h0);

        // Asynchronous reset in the middle of an APPLY window
        pulse_start();
        cyc(int'(S + 1));
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_in",   64'(cut_in), 64'h1);
        chk("async_rst_regs", 64'({signature, pattern_cnt, busy, done, pass}), 64'h0);
        cyc(1);
        rst = 1'b0;
        pulse_start();
        cyc(int'(RUN));
        chk("rerun_result", 64'({done, pass, signature}), 64'({2'b11, gold_n}));

        abort = 1'b1;
        start = 1'b1;
        cyc(1);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_done", 64'({busy, done, pass, signature}), 64'h0);

        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                mode = int'($urandom_range(0, 2));
                case ($urandom_range(0, 2))
                    0:       golden = gold_n;
                    1:       golden = '0;
                    default: golden = 25'($urandom);
                endcase
            end
            start = ($urandom_range(0, 11) == 0);
            abort = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 999) == 0) begin
                start = 1'b0;
                abort = 1'b0;
                @(posedge clk);
                #2 rst = 1'b1;
                cyc(1);
                rst = 1'b0;
            end else begin
                cyc(1);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
